sr_hyp_calc: RTL and testbench
==============================

# sr_hyp_calc

Multi-cycle integer hypotenuse unit for the schoolRISCV core's HYP instruction. It computes y = floor(sqrt(a² + b²)) on the low OPW bits of both operands. It sits beside the ALU, downstream of the register file and srcB mux, and feeds the writeback mux. The core's control stalls the PC while busy_o is high, then writes y on the cycle busy_o falls.

## Interface
- OPW, 16: operand width; the low OPW bits of a and b are used and the upper bits are ignored.
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a  in  32  operand A (rd1)
- b  in  32  operand B (srcB)
- start  in  1  request; level, held high by control for the whole HYP instruction
- y  out  32  result, zero-extended from OPW+1 bits
- busy_o  out  1  PC stall request

## Operation
- States:
  - IDLE
  - MUL_A: a², OPW cycles
  - MUL_B: b², OPW cycles
  - SQRT: OPW+1 cycles
  - DONE: 1 cycle
- IDLE with start=1:
  - latch a[OPW-1:0] and b[OPW-1:0] into internal registers;
  - clear the accumulator;
  - go to MUL_A.
- MUL_A and MUL_B use shift-add with one multiplier bit per cycle, LSB first.
  - Both squares add into one 2*OPW+1-bit accumulator; the sum never overflows.
- SQRT is a restoring digit-by-digit root.
  - The radicand is the accumulator zero-padded to 2*OPW+2 bits.
  - Each cycle: rem = {rem, next 2 radicand MSBs}; trial = {root, 2'b01}.
    - If rem >= trial: rem -= trial and root = {root, 1}.
    - Otherwise: root = {root, 0}.
  - rem is OPW+3 bits wide; root is OPW+1 bits wide.
- On the last SQRT cycle, y is loaded with the zero-extended root and the FSM goes to DONE.
- DONE always returns to IDLE after one cycle. start is ignored in DONE, because the same HYP instruction is still holding start high there.
- start is ignored in MUL_A, MUL_B, SQRT and DONE. a and b may change after the IDLE accept cycle without affecting the result.
- busy_o = (state==IDLE & start) | state ∈ {MUL_A, MUL_B, SQRT}.
  - This is combinational in start, so the accept cycle already stalls the PC.
  - busy_o is 0 in DONE and is forced to 0 while rst_n=0.
- y holds its value until the next result load. It is not cleared by a new start.

## Timing
- Reset values: state=IDLE, y=0, busy_o=0; internal registers cleared.
- Take cycle 0 as an IDLE cycle with start=1:
  - MUL_A occupies cycles 1..OPW.
  - MUL_B occupies cycles OPW+1..2*OPW.
  - SQRT occupies cycles 2*OPW+1..3*OPW+1.
  - DONE is cycle 3*OPW+2, which is 50 for OPW=16.
- busy_o is high for exactly 3*OPW+2 cycles, cycles 0..49.
- y is valid from DONE onward. The core samples it at the end of DONE while busy_o=0.
- Back-to-back requests: if start is high in the IDLE cycle after DONE (next instruction is also HYP), it is accepted there, so there is exactly one non-busy cycle between ops.
- Reset asserted mid-operation aborts immediately:
  - busy_o=0 and y=0 asynchronously;
  - the FSM resumes in IDLE after release.

## Structure
- State encodings (`CALC_IDLE, `CALC_MUL_A, `CALC_MUL_B, `CALC_SQRT, `CALC_DONE) go in sr_cpu.vh next to the ALU and opcode defines.
- The RVOP_HYP and RVF3_HYP defines also live in sr_cpu.vh.
- Sub-module: sr_isqrt_step is the combinational single iteration of the root, taking rem, root and 2 radicand bits and returning the next rem and root. Top-level FSM, counter, multiplier and registers stay in sr_hyp_calc.
- The iteration counter is $clog2(OPW+1) bits and is reloaded on each state entry.

## Test plan
- a=3, b=4, start pulse → busy_o high cycles 0..49; DONE at cycle 50 with y=5; y=5 held afterwards.
- a=5, b=12, then a=0, b=0 → y=13, then y=0, each after 50 busy cycles.
- a=0xFFFF, b=0xFFFF → y=0x16A08 (92680).
- a=0xABCD0003, b=0x00010004 (upper bits set) → y=5. Change a and b at cycle 5 → y still 5.
- start held high continuously → computations accepted at cycles 0 and 51, one non-busy cycle (DONE) between them, with no spurious restart in DONE.
- rst_n low at cycle 20 of an op → busy_o=0 and y=0 immediately. After release, start with a=8, b=6 → y=10 at exactly 50 cycles.

Source files
------------

// File: rtl/sr_hyp_calc_pkg.sv
// Shared definitions for the HYP hypotenuse unit: operand width,
// opcode fields of the HYP instruction and the FSM state encoding.
package sr_hyp_calc_pkg;

  localparam int HYP_OPW = 16;

  localparam logic [6:0] RVOP_HYP = 7'b0001011;
  localparam logic [2:0] RVF3_HYP = 3'b000;

  typedef enum logic [2:0] {
    CALC_IDLE  = 3'd0,
    CALC_MUL_A = 3'd1,
    CALC_MUL_B = 3'd2,
    CALC_SQRT  = 3'd3,
    CALC_DONE  = 3'd4
  } calc_state_t;

endpackage

// File: rtl/sr_hyp_calc_isqrt_step.sv
// One restoring square-root digit: shifts two radicand bits into rem,
// compares against {root,01} and returns the updated rem and root.
// Ports: i_rem/i_root/i_bits current state, o_rem/o_root next state.
module sr_isqrt_step #(
  parameter int OPW = 16
) (
  input  logic [OPW+2:0] i_rem,
  input  logic [OPW:0]   i_root,
  input  logic [1:0]     i_bits,
  output logic [OPW+2:0] o_rem,
  output logic [OPW:0]   o_root
);

  logic [OPW+2:0] w_sh;
  logic [OPW+2:0] w_trial;
  logic [OPW+2:0] w_diff;
  logic           w_ge;
  logic           w_unused;

  // rem never exceeds 2*root, so its two top bits are always
  // zero before the shift and can be dropped.
  assign w_sh     = {i_rem[OPW:0], i_bits};
  assign w_trial  = {i_root, 2'b01};
  assign w_ge     = (w_sh >= w_trial);
  assign w_diff   = w_sh - w_trial;
  assign o_rem    = w_ge ? w_diff : w_sh;
  assign o_root   = {i_root[OPW-1:0], w_ge};
  assign w_unused = ^i_rem[OPW+2:OPW+1];

endmodule

// File: rtl/sr_hyp_calc.sv
// Multi-cycle y = floor(sqrt(a^2 + b^2)) on the low OPW operand bits.
// Ports: clk, rst_n, a, b, start in; y result, busy_o PC stall out.
module sr_hyp_calc
  import sr_hyp_calc_pkg::*;
#(
  parameter int OPW = HYP_OPW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic [31:0] y,
  output logic        busy_o
);

  localparam int CW = $clog2(OPW + 1);
  localparam int AW = 2 * OPW + 1;
  localparam int RW = 2 * OPW + 2;

  calc_state_t r_state;
  calc_state_t w_next;

  logic [OPW-1:0]   r_b;
  logic [OPW-1:0]   r_mpy;
  logic [2*OPW-1:0] r_mcd;
  logic [AW-1:0]    r_acc;
  logic [RW-1:0]    r_rad;
  logic [OPW+2:0]   r_rem;
  logic [OPW:0]     r_root;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_y;

  logic [AW-1:0]    w_acc_nxt;
  logic [OPW+2:0]   w_rem_nxt;
  logic [OPW:0]     w_root_nxt;
  logic             w_last;
  logic             w_busy;
  logic             w_unused;

  assign w_last    = (r_cnt == '0);
  assign w_acc_nxt = r_mpy[0] ? r_acc + {1'b0, r_mcd} : r_acc;
  assign w_unused  = ^{a[31:OPW], b[31:OPW]};

  sr_isqrt_step #(
    .OPW (OPW)
  ) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_rad[RW-1:RW-2]),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CALC_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    unique case (r_state)
      CALC_IDLE: begin
        if (start) begin
          w_next = CALC_MUL_A;
          w_busy = 1'b1;
        end
      end
      CALC_MUL_A: begin
        w_busy = 1'b1;
        if (w_last) w_next = CALC_MUL_B;
      end
      CALC_MUL_B: begin
        w_busy = 1'b1;
        if (w_last) w_next = CALC_SQRT;
      end
      CALC_SQRT: begin
        w_busy = 1'b1;
        if (w_last) w_next = CALC_DONE;
      end
      CALC_DONE: w_next = CALC_IDLE;
      default:   w_next = CALC_IDLE;
    endcase
  end

  // Reset gates the stall so the core is released at once.
  assign busy_o = rst_n & w_busy;
  assign y      = r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b    <= '0;
      r_mpy  <= '0;
      r_mcd  <= '0;
      r_acc  <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
    end else begin
      unique case (r_state)
        CALC_IDLE: begin
          if (start) begin
            r_b   <= b[OPW-1:0];
            r_mpy <= a[OPW-1:0];
            r_mcd <= {{OPW{1'b0}}, a[OPW-1:0]};
            r_acc <= '0;
            r_cnt <= CW'(OPW - 1);
          end
        end
        CALC_MUL_A: begin
          r_acc <= w_acc_nxt;
          r_mcd <= r_mcd << 1;
          r_mpy <= r_mpy >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_mpy <= r_b;
            r_mcd <= {{OPW{1'b0}}, r_b};
            r_cnt <= CW'(OPW - 1);
          end
        end
        CALC_MUL_B: begin
          r_acc <= w_acc_nxt;
          r_mcd <= r_mcd << 1;
          r_mpy <= r_mpy >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_rad  <= {1'b0, w_acc_nxt};
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= CW'(OPW);
          end
        end
        CALC_SQRT: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (w_last) r_y <= {{(31 - OPW){1'b0}}, w_root_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_hyp_calc.sv
// Self-checking bench for sr_hyp_calc: directed and random operands
// against an integer square-root model, plus timing and reset checks.
module tb_sr_hyp_calc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] y;
  logic        busy_o;

  int npass = 0;
  int ntot  = 0;

  sr_hyp_calc dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .start  (start),
    .y      (y),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_hyp(logic [31:0] ta, logic [31:0] tb);
    longint unsigned x, z, n, r, t;
    x = ta[15:0];
    z = tb[15:0];
    n = x * x + z * z;
    r = 0;
    for (int k = 17; k >= 0; k--) begin
      t = r | (64'd1 << k);
      if (t * t <= n) r = t;
    end
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                        input bit hold, input int chg,
                        output int nbusy);
    @(posedge clk);
    #1;
    a = ta;
    b = tb;
    start = 1'b1;
    nbusy = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy_o) break;
      nbusy++;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      if (c + 1 == chg) begin
        a = $urandom;
        b = $urandom;
      end
    end
  endtask

  task automatic op(input string tag, input logic [31:0] ta,
                    input logic [31:0] tb, input logic [31:0] ey,
                    input bit hold, input int chg);
    int nb;
    run_op(ta, tb, hold, chg, nb);
    chk({tag, ":busy_cycles"}, nb, 32'd50);
    chk({tag, ":y"}, y, ey);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int nb;

    start = 1'b1;
    #12;
    chk("rst:busy", {31'd0, busy_o}, 32'd0);
    chk("rst:y", y, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle:busy", {31'd0, busy_o}, 32'd0);

    op("3_4", 32'd3, 32'd4, 32'd5, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("3_4:hold_y", y, 32'd5);
    chk("3_4:idle", {31'd0, busy_o}, 32'd0);

    op("5_12", 32'd5, 32'd12, 32'd13, 1'b0, -1);
    op("0_0", 32'd0, 32'd0, 32'd0, 1'b0, -1);
    op("max", 32'hFFFF, 32'hFFFF, 32'h16A08, 1'b0, -1);
    op("upper", 32'hABCD0003, 32'h00010004, 32'd5, 1'b0, 5);

    // start held high across two back-to-back operations
    op("b2b0", 32'd3, 32'd4, 32'd5, 1'b1, -1);
    chk("b2b:done_busy", {31'd0, busy_o}, 32'd0);
    op("b2b1", 32'd5, 32'd12, 32'd13, 1'b1, -1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b:idle", {31'd0, busy_o}, 32'd0);

    // reset in the middle of an operation
    @(posedge clk);
    #1;
    a = 32'd100;
    b = 32'd200;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort:busy", {31'd0, busy_o}, 32'd0);
    chk("abort:y", y, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op("8_6", 32'd8, 32'd6, 32'd10, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i < 3) ra[15:8] = 8'hFF;
      run_op(ra, rb, 1'b0, (i % 2 == 0) ? 7 : -1, nb);
      chk("rand:busy_cycles", nb, 32'd50);
      chk("rand:y", y, ref_hyp(ra, rb));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
